// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants, FSM state type, ATANH table and shift
//                schedule for the sequential hyperbolic CORDIC.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int CORDIC_DATA_W  = 20;
    localparam int CORDIC_FRAC_W  = 16;
    localparam int CORDIC_N_ITER  = 18;
    localparam int CORDIC_SHIFT_W = 5;

    // 1/K for the 1..16 schedule with 4 and 13 repeated, in Q.16
    localparam logic [31:0] K_INV_Q16 = 32'h0001_351E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shift for iteration index k: 1,2,3,4,4,5,...,13,13,14,15,16
    function automatic logic [CORDIC_SHIFT_W-1:0] shift_of(input int k);
        if (k <= 3)
            return CORDIC_SHIFT_W'(k + 1);
        else if (k <= 13)
            return CORDIC_SHIFT_W'(k);
        else
            return CORDIC_SHIFT_W'(k - 1);
    endfunction

    // atanh(2^-s) rounded to Q.16
    function automatic logic [31:0] atanh_q16(input logic [CORDIC_SHIFT_W-1:0] s);
        case (s)
            5'd1:    return 32'd35999;
            5'd2:    return 32'd16739;
            5'd3:    return 32'd8235;
            5'd4:    return 32'd4101;
            5'd5:    return 32'd2049;
            5'd6:    return 32'd1024;
            5'd7:    return 32'd512;
            5'd8:    return 32'd256;
            5'd9:    return 32'd128;
            5'd10:   return 32'd64;
            5'd11:   return 32'd32;
            5'd12:   return 32'd16;
            5'd13:   return 32'd8;
            5'd14:   return 32'd4;
            5'd15:   return 32'd2;
            5'd16:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // Rescale a non-negative Q.16 constant to a datapath with 'frac' fraction bits
    function automatic logic [31:0] q16_scale(input logic [31:0] v, input int frac);
        if (frac >= 16)
            return v << (frac - 16);
        else
            return v >> (16 - frac);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_hyp_iter.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_hyp_iter
//  Description : One combinational hyperbolic CORDIC micro-rotation.
//                Direction follows the sign of z; shifts are arithmetic,
//                adds wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_hyp_iter #(
    parameter int DATA_W  = 20,
    parameter int SHIFT_W = 5
) (
    input  logic signed [DATA_W-1:0]  i_x,
    input  logic signed [DATA_W-1:0]  i_y,
    input  logic signed [DATA_W-1:0]  i_z,
    input  logic signed [DATA_W-1:0]  i_atanh,
    input  logic        [SHIFT_W-1:0] i_shift,
    output logic signed [DATA_W-1:0]  o_x,
    output logic signed [DATA_W-1:0]  o_y,
    output logic signed [DATA_W-1:0]  o_z
);

    logic signed [DATA_W-1:0] w_xs;
    logic signed [DATA_W-1:0] w_ys;
    logic                     w_pos;

    assign w_xs  = i_x >>> i_shift;
    assign w_ys  = i_y >>> i_shift;
    assign w_pos = ~i_z[DATA_W-1];

    // Rotate toward z = 0 using the pre-rotation x and y
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (w_pos) begin
            o_x = i_x + w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - i_atanh;
        end else begin
            o_x = i_x - w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + i_atanh;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_hyp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_hyp_seq
//  Description : Sequential hyperbolic CORDIC computing cosh, sinh and exp of
//                a signed fixed-point argument, one micro-rotation per cycle
//                through a single shared rotation stage.
//                Optional macro CORDIC_CLAMP_EN clamps z_in to [-1.0, +1.0]
//                and flags the clamp on 'sat'.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_hyp_seq
    import cordic_pkg::*;
#(
    parameter int DATA_W = CORDIC_DATA_W,
    parameter int FRAC_W = CORDIC_FRAC_W,
    parameter int N_ITER = CORDIC_N_ITER
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] z_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] cosh_out,
    output logic signed [DATA_W-1:0] sinh_out,
    output logic signed [DATA_W-1:0] exp_out,
    output logic                     sat
);

    localparam int CNT_W = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_ITER - 1);
    localparam logic signed [DATA_W-1:0] C_K_INV = DATA_W'(q16_scale(K_INV_Q16, FRAC_W));

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_x;
    logic signed [DATA_W-1:0] r_y;
    logic signed [DATA_W-1:0] r_z;
    logic signed [DATA_W-1:0] r_cosh;
    logic signed [DATA_W-1:0] r_sinh;
    logic signed [DATA_W-1:0] r_exp;
    logic                     r_in_ready;
    logic                     r_out_valid;

    logic [CORDIC_SHIFT_W-1:0] w_shift;
    logic signed [DATA_W-1:0]  w_atanh;
    logic signed [DATA_W-1:0]  w_x_nxt;
    logic signed [DATA_W-1:0]  w_y_nxt;
    logic signed [DATA_W-1:0]  w_z_nxt;
    logic signed [DATA_W-1:0]  w_z_load;
    logic                      w_accept;

    assign w_accept = (r_state == ST_IDLE) && r_in_ready && in_valid;
    assign w_shift  = shift_of(int'(r_cnt));
    assign w_atanh  = DATA_W'(q16_scale(atanh_q16(w_shift), FRAC_W));

`ifdef CORDIC_CLAMP_EN
    localparam logic signed [DATA_W-1:0] C_POS_ONE = DATA_W'(64'sd1 <<< FRAC_W);
    localparam logic signed [DATA_W-1:0] C_NEG_ONE = -C_POS_ONE;

    logic w_clamp;
    logic r_sat;

    // Limit the argument to [-1.0, +1.0], well inside the convergence range
    always_comb begin
        w_z_load = z_in;
        w_clamp  = 1'b0;
        if (z_in > C_POS_ONE) begin
            w_z_load = C_POS_ONE;
            w_clamp  = 1'b1;
        end else if (z_in < C_NEG_ONE) begin
            w_z_load = C_NEG_ONE;
            w_clamp  = 1'b1;
        end
    end

    // Clamp flag is captured with the argument and kept for the transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat <= 1'b0;
        else if (w_accept)
            r_sat <= w_clamp;
    end

    assign sat = r_sat;
`else
    assign w_z_load = z_in;
    assign sat      = 1'b0;
`endif

    cordic_hyp_iter #(
        .DATA_W  (DATA_W),
        .SHIFT_W (CORDIC_SHIFT_W)
    ) u_iter (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_atanh (w_atanh),
        .i_shift (w_shift),
        .o_x     (w_x_nxt),
        .o_y     (w_y_nxt),
        .o_z     (w_z_nxt)
    );

    // Control FSM plus datapath/result registers; results load on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_cosh      <= '0;
            r_sinh      <= '0;
            r_exp       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_x        <= C_K_INV;
                        r_y        <= '0;
                        r_z        <= w_z_load;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    r_z   <= w_z_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_cosh      <= w_x_nxt;
                        r_sinh      <= w_y_nxt;
                        r_exp       <= w_x_nxt + w_y_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign cosh_out  = r_cosh;
    assign sinh_out  = r_sinh;
    assign exp_out   = r_exp;

endmodule
`default_nettype wire

// File: tb/tb_cordic_hyp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_hyp_seq
//  Description : Directed self-checking bench for cordic_hyp_seq: reset
//                state, latency, known cosh/sinh/exp values, clamp
//                behaviour, output back-pressure and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_hyp_seq;

    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] z_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] cosh_out;
    logic [DW-1:0] sinh_out;
    logic [DW-1:0] exp_out;
    logic          sat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cordic_hyp_seq #(
        .DATA_W (20),
        .FRAC_W (16),
        .N_ITER (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cosh_out  (cosh_out),
        .sinh_out  (sinh_out),
        .exp_out   (exp_out),
        .sat       (sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        logic signed [DW-1:0] d;
        logic                 ok;
        d  = obs - exp;
        ok = (d <= 8) && (d >= -8);
        n_checks++;
        assert (ok === 1'b1) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%05h expected=0x%05h (+/-8)", tag, obs, exp);
        end
    endtask

    // Offer z, complete the handshake and check the input side closes
    task automatic accept(input string tag, input logic [DW-1:0] z);
        check_eq({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        z_in     = z;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    // Bounded wait for out_valid; latency must be exactly 18 edges after accept
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'd18);
    endtask

    task automatic run_vec(input string tag, input logic [DW-1:0] z,
                           input logic [DW-1:0] e_cosh, input logic [DW-1:0] e_sinh,
                           input logic [DW-1:0] e_exp);
        accept(tag, z);
        wait_done(tag);
        check_near({tag, "_cosh"}, cosh_out, e_cosh);
        check_near({tag, "_sinh"}, sinh_out, e_sinh);
        check_near({tag, "_exp"},  exp_out,  e_exp);
        check_eq({tag, "_sat"}, 32'(sat), 32'd0);
        tick();
        check_eq({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        z_in      = '0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_cosh",      32'(cosh_out),  32'd0);
        check_eq("rst_sinh",      32'(sinh_out),  32'd0);
        check_eq("rst_exp",       32'(exp_out),   32'd0);
        check_eq("rst_sat",       32'(sat),       32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready_pre", 32'(in_ready), 32'd0);
        tick();
        check_eq("rel_in_ready_post", 32'(in_ready), 32'd1);

        // Known arguments
        run_vec("z0",    20'h00000, 20'h10000, 20'h00000, 20'h10000);
        run_vec("zp05",  20'h08000, 20'h120AC, 20'h08567, 20'h1A613);
        run_vec("zm05",  20'hF8000, 20'h120AC, 20'hF7A99, 20'h09B46);

        // Out-of-range argument
        accept("z2", 20'h20000);
        wait_done("z2");
`ifdef CORDIC_CLAMP_EN
        check_eq("z2_sat", 32'(sat), 32'd1);
        check_near("z2_cosh", cosh_out, 20'h18B07);
        check_near("z2_sinh", sinh_out, 20'h12CDA);
        check_near("z2_exp",  exp_out,  20'h2B7E1);
`else
        check_eq("z2_sat", 32'(sat), 32'd0);
`endif
        tick();
        check_eq("z2_out_valid_after", 32'(out_valid), 32'd0);

        // Back-pressure: results hold while out_ready is low, new input ignored
        out_ready = 1'b0;
        accept("bp", 20'h08000);
        wait_done("bp");
        in_valid = 1'b1;
        z_in     = 20'h20000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready",  32'(in_ready),  32'd0);
            check_near("bp_cosh", cosh_out, 20'h120AC);
            check_near("bp_sinh", sinh_out, 20'h08567);
            check_near("bp_exp",  exp_out,  20'h1A613);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("bp_rel_out_valid", 32'(out_valid), 32'd0);
        check_eq("bp_rel_in_ready",  32'(in_ready),  32'd1);
        check_near("bp_hold_cosh", cosh_out, 20'h120AC);

        // Reset during iteration 7 discards the computation
        accept("mr", 20'hF8000);
        repeat (7) tick();
        check_eq("mr_busy_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("mr_cosh",      32'(cosh_out),  32'd0);
        check_eq("mr_sinh",      32'(sinh_out),  32'd0);
        check_eq("mr_exp",       32'(exp_out),   32'd0);
        check_eq("mr_out_valid", 32'(out_valid), 32'd0);
        check_eq("mr_in_ready",  32'(in_ready),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("mr_rel_in_ready", 32'(in_ready), 32'd1);
        run_vec("mr_zp05", 20'h08000, 20'h120AC, 20'h08567, 20'h1A613);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
